ip_decoder: RTL and testbench

Receive-side IPv4 header decoder for the UDP/TCP stack. It accepts a packet as a stream of 32-bit big-endian words, one word per clock, and registers every IPv4 header field. It verifies the header checksum, skips any options, and forwards payload words to the transport-layer decoder (UDP/TCP) with a write strobe, payload byte length and end-of-packet flag.

---
 rtl/ip_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_ip_decoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ip_decoder.sv
// Receive-side IPv4 header decoder: captures header fields, checks lengths (and checksum
// when IP_CHECKSUM_EN is defined), drops options and forwards payload words with wr_en/fin.
module ip_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data,
   input  logic        start,
   output logic [3:0]  version,
   output logic [3:0]  IHL,
   output logic [7:0]  type_of_ser,
   output logic [15:0] total_length,
   output logic [15:0] identification,
   output logic [2:0]  flag,
   output logic [12:0] frag_offset,
   output logic [7:0]  time_to_live,
   output logic [7:0]  protocol,
   output logic [31:0] src_ip,
   output logic [31:0] dest_ip,
   output logic [15:0] len_out,
   output logic [31:0] data_out,
   output logic        wr_en,
   output logic        ok,
   output logic        fin
);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_OPTIONS, S_PAYLOAD} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  hdr_cnt;
   logic [3:0]  opt_cnt;
   logic [14:0] pay_cnt;
   logic [15:0] head_chks16;
   logic        csum_good;

   logic [15:0] hdr_bytes;
   logic        malformed;
   logic [16:0] pay_round;
   logic [14:0] pay_words;
   logic        hdr_last;
   logic        opt_last;
   logic        pay_last;

   logic        hdr_done;
   logic        enter_payload;
   logic        fin_nxt;
   logic        wr_nxt;
   logic        ok_nxt;

   // Header checks work on the registered word-0 fields, which are stable from word 1 on.
   assign hdr_bytes = {10'd0, IHL, 2'b00};
   assign malformed = (IHL < 4'd5) || (total_length < hdr_bytes);
   assign pay_round = {1'b0, len_out} + 17'd3;
   assign pay_words = pay_round[16:2];
   assign hdr_last  = (state == S_HEADER)  && (hdr_cnt == 3'd4);
   assign opt_last  = (state == S_OPTIONS) && (opt_cnt == 4'd1);
   assign pay_last  = (state == S_PAYLOAD) && (pay_cnt == 15'd1);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_HEADER;
         end
         S_HEADER: begin
            if (hdr_cnt == 3'd4) begin
               if (malformed)              state_nxt = S_IDLE;
               else if (IHL > 4'd5)        state_nxt = S_OPTIONS;
               else if (len_out == 16'd0)  state_nxt = S_IDLE;
               else                        state_nxt = S_PAYLOAD;
            end
         end
         S_OPTIONS: begin
            if (opt_cnt == 4'd1) begin
               if (len_out == 16'd0) state_nxt = S_IDLE;
               else                  state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (pay_cnt == 15'd1) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: next values of the registered control outputs
   always_comb begin
      hdr_done      = (hdr_last && (malformed || (IHL == 4'd5))) || opt_last;
      enter_payload = (state_nxt == S_PAYLOAD) && (state != S_PAYLOAD);
      fin_nxt       = (hdr_done && (state_nxt == S_IDLE)) || pay_last;
      wr_nxt        = (state == S_PAYLOAD);
      ok_nxt        = (version == 4'd4) && !malformed && csum_good;
   end

   // Sequencing counters
   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_cnt <= 3'd0;
         opt_cnt <= 4'd0;
         pay_cnt <= 15'd0;
      end else begin
         if (state == S_IDLE)        hdr_cnt <= 3'd1;
         else if (state == S_HEADER) hdr_cnt <= hdr_cnt + 3'd1;

         if (hdr_last)                opt_cnt <= IHL - 4'd5;
         else if (state == S_OPTIONS) opt_cnt <= opt_cnt - 4'd1;

         if (enter_payload)           pay_cnt <= pay_words;
         else if (state == S_PAYLOAD) pay_cnt <= pay_cnt - 15'd1;
      end
   end

`ifdef IP_CHECKSUM_EN
   logic [15:0] acc_base;
   logic [15:0] acc_sum;

   // Ones'-complement fold of a three-operand sum back into 16 bits.
   function automatic logic [15:0] fold(input logic [17:0] s);
      logic [16:0] t;
      t = {1'b0, s[15:0]} + {15'd0, s[17:16]};
      return t[15:0] + {15'd0, t[16]};
   endfunction

   always_comb begin
      acc_base = (state == S_IDLE) ? 16'h0000 : head_chks16;
      acc_sum  = fold({2'b00, acc_base} + {2'b00, data[31:16]} + {2'b00, data[15:0]});
   end

   always_ff @(posedge clk) begin
      if (reset)
         head_chks16 <= 16'h0000;
      else if (((state == S_IDLE) && start) || (state == S_HEADER) || (state == S_OPTIONS))
         head_chks16 <= acc_sum;
   end

   assign csum_good = (acc_sum == 16'hFFFF);
`else
   assign head_chks16 = 16'h0000;
   assign csum_good   = (head_chks16 == 16'h0000);
`endif

   // Registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         version        <= 4'd0;
         IHL            <= 4'd0;
         type_of_ser    <= 8'd0;
         total_length   <= 16'd0;
         identification <= 16'd0;
         flag           <= 3'd0;
         frag_offset    <= 13'd0;
         time_to_live   <= 8'd0;
         protocol       <= 8'd0;
         src_ip         <= 32'd0;
         dest_ip        <= 32'd0;
         len_out        <= 16'd0;
         data_out       <= 32'd0;
         wr_en          <= 1'b0;
         ok             <= 1'b0;
         fin            <= 1'b0;
      end else begin
         wr_en <= wr_nxt;
         fin   <= fin_nxt;
         if (wr_nxt) data_out <= data;

         if ((state == S_IDLE) && start) begin
            version      <= data[31:28];
            IHL          <= data[27:24];
            type_of_ser  <= data[23:16];
            total_length <= data[15:0];
            len_out      <= data[15:0] - {10'd0, data[27:24], 2'b00};
            ok           <= 1'b0;
         end

         if (state == S_HEADER) begin
            case (hdr_cnt)
               3'd1: begin
                  identification <= data[31:16];
                  flag           <= data[15:13];
                  frag_offset    <= data[12:0];
               end
               3'd2: begin
                  time_to_live <= data[31:24];
                  protocol     <= data[23:16];
               end
               3'd3:    src_ip  <= data;
               3'd4:    dest_ip <= data;
               default: ;
            endcase
         end

         if (hdr_done) ok <= ok_nxt;
      end
   end

endmodule

// File: tb/tb_ip_decoder.sv
// Directed bench for ip_decoder: nominal, bad checksum, options, empty payload,
// malformed IHL, back-to-back start and mid-payload reset.
module tb_ip_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data;
   logic        start;
   logic [3:0]  version;
   logic [3:0]  IHL;
   logic [7:0]  type_of_ser;
   logic [15:0] total_length;
   logic [15:0] identification;
   logic [2:0]  flag;
   logic [12:0] frag_offset;
   logic [7:0]  time_to_live;
   logic [7:0]  protocol;
   logic [31:0] src_ip;
   logic [31:0] dest_ip;
   logic [15:0] len_out;
   logic [31:0] data_out;
   logic        wr_en;
   logic        ok;
   logic        fin;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] hdr [0:5];
   logic [31:0] pay [0:2];
   logic        exp_bad_ok;

   ip_decoder dut (
      .clk(clk), .reset(reset), .data(data), .start(start),
      .version(version), .IHL(IHL), .type_of_ser(type_of_ser),
      .total_length(total_length), .identification(identification),
      .flag(flag), .frag_offset(frag_offset), .time_to_live(time_to_live),
      .protocol(protocol), .src_ip(src_ip), .dest_ip(dest_ip),
      .len_out(len_out), .data_out(data_out), .wr_en(wr_en), .ok(ok), .fin(fin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one word for one clock; outputs are examined 1 time unit after the edge.
   task automatic cyc(input logic [31:0] w, input logic st, input logic rst);
      data  = w;
      start = st;
      reset = rst;
      @(posedge clk);
      #1;
   endtask

   // Writes the header checksum field so the n header words sum to FFFF.
   task automatic fix_csum(input int n);
      logic [15:0] acc;
      logic [16:0] t;
      hdr[2][15:0] = 16'h0000;
      acc = 16'h0000;
      for (int i = 0; i < n; i++) begin
         t   = {1'b0, acc} + {1'b0, hdr[i][31:16]};
         acc = t[15:0] + {15'd0, t[16]};
         t   = {1'b0, acc} + {1'b0, hdr[i][15:0]};
         acc = t[15:0] + {15'd0, t[16]};
      end
      hdr[2][15:0] = ~acc;
   endtask

   task automatic send_header(input int n);
      cyc(hdr[0], 1'b1, 1'b0);
      for (int i = 1; i < n; i++) cyc(hdr[i], 1'b0, 1'b0);
   endtask

   task automatic nominal_hdr();
      hdr[0] = 32'h4500001F;
      hdr[1] = 32'h04D2007B;
      hdr[2] = 32'h0A110000;
      hdr[3] = 32'h9801331B;
      hdr[4] = 32'h980E5E4B;
      fix_csum(5);
   endtask

   task automatic send_payload(input string tag);
      for (int i = 0; i < 3; i++) begin
         cyc(pay[i], 1'b0, 1'b0);
         chk({tag, "_wr"},   {31'd0, wr_en}, 32'd1);
         chk({tag, "_data"}, data_out, pay[i]);
         chk({tag, "_fin"},  {31'd0, fin}, (i == 2) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
`ifdef IP_CHECKSUM_EN
      exp_bad_ok = 1'b0;
`else
      exp_bad_ok = 1'b1;
`endif
      pay[0] = 32'h48656C6C;
      pay[1] = 32'h6F20576F;
      pay[2] = 32'h726C6400;
      data = 32'd0; start = 1'b0; reset = 1'b1;

      // Reset state
      cyc(32'hFFFFFFFF, 1'b1, 1'b1);
      cyc(32'd0, 1'b0, 1'b1);
      chk("rst_version", {28'd0, version}, 32'd0);
      chk("rst_len",     {16'd0, len_out}, 32'd0);
      chk("rst_src",     src_ip, 32'd0);
      chk("rst_wr",      {31'd0, wr_en}, 32'd0);
      chk("rst_ok",      {31'd0, ok}, 32'd0);
      chk("rst_fin",     {31'd0, fin}, 32'd0);
      cyc(32'd0, 1'b0, 1'b0);

      // Nominal packet, with a stray start on word 1 that must be ignored
      nominal_hdr();
      cyc(hdr[0], 1'b1, 1'b0);
      chk("nom_version", {28'd0, version}, 32'd4);
      chk("nom_ihl",     {28'd0, IHL}, 32'd5);
      chk("nom_tos",     {24'd0, type_of_ser}, 32'h00);
      chk("nom_totlen",  {16'd0, total_length}, 32'd31);
      chk("nom_len",     {16'd0, len_out}, 32'd11);
      cyc(hdr[1], 1'b1, 1'b0);
      chk("nom_id",      {16'd0, identification}, 32'd1234);
      chk("nom_flag",    {29'd0, flag}, 32'd0);
      chk("nom_frag",    {19'd0, frag_offset}, 32'd123);
      chk("nom_ver_hold", {28'd0, version}, 32'd4);
      cyc(hdr[2], 1'b0, 1'b0);
      chk("nom_ttl",     {24'd0, time_to_live}, 32'd10);
      chk("nom_proto",   {24'd0, protocol}, 32'h11);
      cyc(hdr[3], 1'b0, 1'b0);
      chk("nom_src",     src_ip, 32'h9801331B);
      chk("nom_hdr_wr",  {31'd0, wr_en}, 32'd0);
      cyc(hdr[4], 1'b0, 1'b0);
      chk("nom_dst",     dest_ip, 32'h980E5E4B);
      chk("nom_ok",      {31'd0, ok}, 32'd1);
      chk("nom_w4_wr",   {31'd0, wr_en}, 32'd0);
      chk("nom_w4_fin",  {31'd0, fin}, 32'd0);
      send_payload("nom");

      // Bad checksum, starting the cycle right after fin
      nominal_hdr();
      hdr[2][0] = ~hdr[2][0];
      send_header(5);
      chk("bad_ok",      {31'd0, ok}, {31'd0, exp_bad_ok});
      chk("bad_nom_wr",  {31'd0, wr_en}, 32'd0);
      send_payload("bad");
      cyc(32'h12345678, 1'b0, 1'b0);
      chk("idle_wr",     {31'd0, wr_en}, 32'd0);
      chk("idle_fin",    {31'd0, fin}, 32'd0);
      chk("idle_hold",   data_out, 32'h726C6400);

      // One option word
      hdr[0] = 32'h46000023;
      hdr[1] = 32'h04D2007B;
      hdr[2] = 32'h0A110000;
      hdr[3] = 32'h9801331B;
      hdr[4] = 32'h980E5E4B;
      hdr[5] = 32'h00000000;
      fix_csum(6);
      send_header(5);
      chk("opt_len",     {16'd0, len_out}, 32'd11);
      chk("opt_w4_wr",   {31'd0, wr_en}, 32'd0);
      chk("opt_w4_fin",  {31'd0, fin}, 32'd0);
      cyc(hdr[5], 1'b0, 1'b0);
      chk("opt_ok",      {31'd0, ok}, 32'd1);
      chk("opt_skip_wr", {31'd0, wr_en}, 32'd0);
      send_payload("opt");

      // Header-only packet
      hdr[0] = 32'h45000014;
      hdr[1] = 32'h04D2007B;
      hdr[2] = 32'h0A110000;
      hdr[3] = 32'h9801331B;
      hdr[4] = 32'h980E5E4B;
      fix_csum(5);
      send_header(5);
      chk("empty_len",   {16'd0, len_out}, 32'd0);
      chk("empty_ok",    {31'd0, ok}, 32'd1);
      chk("empty_fin",   {31'd0, fin}, 32'd1);
      chk("empty_wr",    {31'd0, wr_en}, 32'd0);
      cyc(32'hAAAA5555, 1'b0, 1'b0);
      chk("empty_fin2",  {31'd0, fin}, 32'd0);
      chk("empty_wr2",   {31'd0, wr_en}, 32'd0);
      chk("empty_okhold", {31'd0, ok}, 32'd1);

      // Malformed IHL=4, followed immediately by a nominal packet
      hdr[0] = 32'h44000020;
      send_header(5);
      chk("ihl4_len",    {16'd0, len_out}, 32'd16);
      chk("ihl4_ok",     {31'd0, ok}, 32'd0);
      chk("ihl4_fin",    {31'd0, fin}, 32'd1);
      chk("ihl4_wr",     {31'd0, wr_en}, 32'd0);
      nominal_hdr();
      send_header(5);
      chk("after_ok",    {31'd0, ok}, 32'd1);
      chk("after_len",   {16'd0, len_out}, 32'd11);
      send_payload("after");

      // Reset during payload word 2
      nominal_hdr();
      send_header(5);
      cyc(pay[0], 1'b0, 1'b0);
      chk("rstp_wr0",    {31'd0, wr_en}, 32'd1);
      cyc(pay[1], 1'b1, 1'b1);
      chk("rstp_wr",     {31'd0, wr_en}, 32'd0);
      chk("rstp_data",   data_out, 32'd0);
      chk("rstp_ok",     {31'd0, ok}, 32'd0);
      chk("rstp_dst",    dest_ip, 32'd0);
      chk("rstp_len",    {16'd0, len_out}, 32'd0);
      cyc(pay[2], 1'b0, 1'b0);
      chk("rstp_fin",    {31'd0, fin}, 32'd0);
      chk("rstp_wr2",    {31'd0, wr_en}, 32'd0);
      send_header(5);
      chk("rec_dst",     dest_ip, 32'h980E5E4B);
      chk("rec_ok",      {31'd0, ok}, 32'd1);
      send_payload("rec");
      cyc(32'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
